// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of committed stores draining to dbus, with word-granular load forwarding.
// Define STORE_BUFFER_MERGE_EN to merge a push into the youngest entry when the word addresses match.
module store_buffer #(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push_valid,
   output logic        push_ready,
   input  logic [31:0] push_addr,
   input  logic [31:0] push_data,
   input  logic [3:0]  push_strobe,
   input  logic [31:0] lkp_addr,
   output logic        sb_fwd_en,
   output logic [31:0] sb_fwd_data,
   output logic [31:0] sb_fwd_addr,
   output logic        lkp_conflict,
   output logic        dreq_valid,
   output logic [31:0] dreq_addr,
   output logic [3:0]  dreq_strobe,
   output logic [31:0] dreq_data,
   input  logic        dresp_addr_ok,
   input  logic        dresp_data_ok,
   output logic        sb_empty
);
   typedef enum logic {IDLE, REQ} state_t;
   state_t state, state_next;
   logic [29:0] addr_q [DEPTH];
   logic [31:0] data_q [DEPTH];
   logic [3:0] strb_q [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0] count, count_next;
   logic full, pop, alloc, can_merge, merge, match;
   logic [31:0] match_data;
   logic [3:0] match_strb;
   logic unused;
   assign unused = &{1'b0, dresp_addr_ok, push_addr[1:0], lkp_addr[1:0]};
   assign full = count == (PTR_W+1)'(DEPTH);
`ifdef STORE_BUFFER_MERGE_EN
   logic [PTR_W-1:0] last;
   assign last = tail - PTR_W'(1);
   // The head is frozen while its request is on the bus, so it never absorbs a merge.
   assign can_merge = count != '0 && addr_q[last] == push_addr[31:2] && !(state == REQ && last == head);
`else
   assign can_merge = 1'b0;
`endif
   assign merge = push_valid && can_merge;
   assign push_ready = !full || can_merge;
   assign alloc = push_valid && !full && !merge;
   assign pop = state == REQ && dresp_data_ok;
   assign count_next = count + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);
   always_comb begin
      state_next = state;
      if (state == IDLE) state_next = count != '0 ? REQ : IDLE;
      else if (pop) state_next = count_next != '0 ? REQ : IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         state <= state_next;
         head <= head + PTR_W'(pop);
         tail <= tail + PTR_W'(alloc);
         count <= count_next;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset && alloc) begin
         addr_q[tail] <= push_addr[31:2];
         data_q[tail] <= push_data;
         strb_q[tail] <= push_strobe;
      end
`ifdef STORE_BUFFER_MERGE_EN
      if (!reset && merge) begin
         for (int b = 0; b < 4; b++)
            if (push_strobe[b]) data_q[last][8*b +: 8] <= push_data[8*b +: 8];
         strb_q[last] <= strb_q[last] | push_strobe;
      end
`endif
   end
   // Scan oldest to youngest so the youngest match overwrites earlier ones.
   always_comb begin
      match = 1'b0;
      match_data = '0;
      match_strb = '0;
      for (int i = 0; i < DEPTH; i++)
         if (i < int'(count) && addr_q[head + PTR_W'(i)] == lkp_addr[31:2]) begin
            match = 1'b1;
            match_data = data_q[head + PTR_W'(i)];
            match_strb = strb_q[head + PTR_W'(i)];
         end
   end
   assign sb_fwd_en = match && match_strb == 4'hF;
   assign lkp_conflict = match && match_strb != 4'hF;
   assign sb_fwd_data = match_data;
   assign sb_fwd_addr = sb_fwd_en ? {lkp_addr[31:2], 2'b00} : '0;
   assign dreq_valid = state == REQ;
   assign dreq_addr = dreq_valid ? {addr_q[head], 2'b00} : '0;
   assign dreq_data = dreq_valid ? data_q[head] : '0;
   assign dreq_strobe = dreq_valid ? strb_q[head] : '0;
   assign sb_empty = count == '0 && state == IDLE;
endmodule
